// File: rtl/sram_cache_pkg.sv
// rtl/sram_cache_pkg.sv - shared states, geometry defaults and address mapping for sram_cache_ctrl
package sram_cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR      = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam int unsigned BASE_ADDR_DEF = 1024;
  localparam int unsigned LINES_DEF     = 64;
  localparam int unsigned WORD_AW       = 17;
  localparam int unsigned IDX_W_DEF     = $clog2(LINES_DEF);
  localparam int unsigned TAG_W_DEF     = WORD_AW - IDX_W_DEF;

  // Word index into data memory; bits above the SRAM reach are dropped.
  function automatic logic [WORD_AW-1:0] word_addr(input logic [31:0] byte_addr,
                                                   input logic [31:0] base);
    return WORD_AW'((byte_addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_cache_array.sv
// rtl/sram_cache_array.sv - direct-mapped one-word lines: valid/tag/data registers
// Combinational lookup, clocked fill, every line invalidated on rst.
module sram_cache_array
  import sram_cache_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [TAG_W-1:0] tag_d  [LINES];
  logic [31:0]      data_q [LINES];
  logic [31:0]      data_d [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/sram_cache_ctrl.sv
// rtl/sram_cache_ctrl.sv - MEM-stage requester with write-through word cache in front of the SRAM controller
// SRAM_CACHE_EN builds the cache; without it every load goes to the controller.
module sram_cache_ctrl
  import sram_cache_pkg::*;
#(
  parameter int unsigned BASE_ADDR = BASE_ADDR_DEF,
  parameter int unsigned LINES     = LINES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_address,
  input  logic [31:0] MEM_write_data,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  output logic [31:0] MEM_read_data,
  output logic        freeze,
  output logic [17:0] SRAM_address,
  output logic [31:0] SRAM_write_data,
  output logic        SRAM_re_en,
  output logic        SRAM_we_en,
  input  logic [31:0] SRAM_read_data,
  input  logic        ready
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = WORD_AW - IDX_W;

  state_e             state_q, state_d;
  logic [17:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [WORD_AW-1:0] w;
  logic               hit;
  logic [31:0]        line_data;
  logic               need_sram;

  assign w               = word_addr(MEM_address, 32'(BASE_ADDR));
  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_re_en      = (state_q == RD_MISS);
  assign SRAM_we_en      = (state_q == WR);
  assign need_sram       = MEM_W_EN | (MEM_R_EN & ~hit);

`ifdef SRAM_CACHE_EN
  logic             line_valid;
  logic [TAG_W-1:0] line_tag;
  logic             fill_en;
  logic [31:0]      fill_data;

  // Fill from the latched request so the line matches what the controller saw.
  assign fill_en   = ready & (SRAM_re_en | SRAM_we_en);
  assign fill_data = SRAM_we_en ? wdata_q : SRAM_read_data;

  sram_cache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (w[IDX_W-1:0]),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (fill_en),
    .wr_idx   (addr_q[IDX_W:1]),
    .wr_tag   (addr_q[WORD_AW:IDX_W+1]),
    .wr_data  (fill_data)
  );

  assign hit = line_valid && (line_tag == w[WORD_AW-1:IDX_W]);
`else
  assign hit       = 1'b0;
  assign line_data = '0;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    freeze        = 1'b0;
    MEM_read_data = '0;
    case (state_q)
      IDLE: begin
        if (need_sram) begin
          freeze = 1'b1;
          addr_d = {w, 1'b0};
          if (MEM_W_EN) begin
            wdata_d = MEM_write_data;
            state_d = WR;
          end else begin
            state_d = RD_MISS;
          end
        end else if (MEM_R_EN) begin
          MEM_read_data = line_data;
        end
      end
      RD_MISS: begin
        if (ready) begin
          MEM_read_data = SRAM_read_data;
          state_d       = RELEASE;
        end else begin
          freeze = 1'b1;
        end
      end
      WR: begin
        if (ready) state_d = RELEASE;
        else       freeze  = 1'b1;
      end
      RELEASE: begin
        // One cycle with both enables low lets the controller rewind its phase.
        state_d = IDLE;
        if (need_sram)     freeze        = 1'b1;
        else if (MEM_R_EN) MEM_read_data = line_data;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_sram_cache_ctrl.sv
// tb/tb_sram_cache_ctrl.sv - scoreboard bench for sram_cache_ctrl with an SRAM controller model
module tb_sram_cache_ctrl;

  localparam int unsigned BASE  = 1024;
  localparam int unsigned LINES = 64;
`ifdef SRAM_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  typedef struct {
    bit          we;
    logic [17:0] addr;
    logic [31:0] data;
  } sreq_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] MEM_address, MEM_write_data, MEM_read_data;
  logic        MEM_R_EN, MEM_W_EN, freeze;
  logic [17:0] SRAM_address;
  logic [31:0] SRAM_write_data, SRAM_read_data;
  logic        SRAM_re_en, SRAM_we_en, ready;

  sram_cache_ctrl #(.BASE_ADDR(BASE), .LINES(LINES)) dut (
    .clk             (clk),
    .rst             (rst),
    .MEM_address     (MEM_address),
    .MEM_write_data  (MEM_write_data),
    .MEM_R_EN        (MEM_R_EN),
    .MEM_W_EN        (MEM_W_EN),
    .MEM_read_data   (MEM_read_data),
    .freeze          (freeze),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_re_en      (SRAM_re_en),
    .SRAM_we_en      (SRAM_we_en),
    .SRAM_read_data  (SRAM_read_data),
    .ready           (ready)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_load[$];
  int          exp_freeze[$];
  sreq_t       exp_sram[$];
  logic [31:0] ref_mem[int];
  logic [31:0] dev_mem[int];
  bit          m_valid[LINES];
  int          m_tag[LINES];
  bit          last_xfer;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event with nothing expected (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] mem_init(input int w);
    return (w == 0) ? 32'hDEADBEEF : 32'(w) * 32'h9E3779B1 + 32'h1234;
  endfunction

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : mem_init(w);
  endfunction

  // SRAM controller: answers in the 4th cycle an enable is held, owns its own memory.
  initial begin
    int ph;
    ph = 0;
    ready = 1'b0;
    SRAM_read_data = 32'hBAD0BAD0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && (SRAM_re_en || SRAM_we_en)) begin
        ph++;
        if (ph == 4) begin
          ready = 1'b1;
          if (SRAM_we_en) dev_mem[int'(SRAM_address[17:1])] = SRAM_write_data;
          else SRAM_read_data = dev_mem.exists(int'(SRAM_address[17:1])) ?
                                dev_mem[int'(SRAM_address[17:1])] : mem_init(int'(SRAM_address[17:1]));
        end else begin
          ready = 1'b0;
          SRAM_read_data = 32'hBAD0BAD0;
        end
      end else begin
        ph = 0;
        ready = 1'b0;
        SRAM_read_data = 32'hBAD0BAD0;
      end
    end
  end

  // Monitor: load responses, freeze lengths, SRAM request starts.
  initial begin
    int    fcnt;
    bit    prev_en, prev_ready;
    sreq_t r;
    fcnt = 0;
    prev_en = 1'b0;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fcnt = 0;
        prev_en = 1'b0;
        prev_ready = 1'b0;
      end else begin
        if (MEM_R_EN && !MEM_W_EN && !freeze) begin
          if (exp_load.size() == 0) fail("load_unexpected");
          else chk("load_data", 64'(MEM_read_data), 64'(exp_load.pop_front()));
        end else begin
          chk("rdata_zero", 64'(MEM_read_data), 64'd0);
        end
        if (MEM_R_EN || MEM_W_EN) begin
          if (freeze) fcnt++;
          else begin
            if (exp_freeze.size() == 0) fail("freeze_unexpected");
            else chk("freeze_cycles", 64'(fcnt), 64'(exp_freeze.pop_front()));
            fcnt = 0;
          end
        end else begin
          chk("freeze_idle", 64'(freeze), 64'd0);
          fcnt = 0;
        end
        if (prev_ready) chk("en_after_ready", 64'(SRAM_re_en | SRAM_we_en), 64'd0);
        if ((SRAM_re_en || SRAM_we_en) && !prev_en) begin
          if (exp_sram.size() == 0) fail("sram_unexpected");
          else begin
            r = exp_sram.pop_front();
            chk("sram_we", 64'(SRAM_we_en), 64'(r.we));
            chk("sram_re", 64'(SRAM_re_en), 64'(!r.we));
            chk("sram_addr", 64'(SRAM_address), 64'(r.addr));
            if (r.we) chk("sram_wdata", 64'(SRAM_write_data), 64'(r.data));
          end
        end
        prev_en = SRAM_re_en || SRAM_we_en;
        prev_ready = ready;
      end
    end
  end

  task automatic do_req(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] data);
    int    w, idx, tag, n;
    bit    hit;
    sreq_t r;
    w   = int'(((addr - 32'(BASE)) >> 2) & 32'h1FFFF);
    idx = w % LINES;
    tag = w / LINES;
    hit = 1'b0;
    if (wr) begin
      r = '{1'b1, 18'(2 * w), data};
      exp_sram.push_back(r);
      ref_mem[w] = data;
    end else begin
      hit = CACHE_ON && m_valid[idx] && (m_tag[idx] == tag);
      exp_load.push_back(ref_rd(w));
      if (!hit) begin
        r = '{1'b0, 18'(2 * w), 32'h0};
        exp_sram.push_back(r);
      end
    end
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
    end
    exp_freeze.push_back(hit ? 0 : (last_xfer ? 5 : 4));
    MEM_address    = addr;
    MEM_write_data = data;
    MEM_W_EN       = wr;
    MEM_R_EN       = rd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (freeze && n < 40);
    if (freeze) chk("req_timeout", 64'(freeze), 64'd0);
    @(posedge clk);
    #1;
    MEM_R_EN       = 1'b0;
    MEM_W_EN       = 1'b0;
    MEM_address    = $urandom;
    MEM_write_data = $urandom;
    last_xfer      = !hit;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
      last_xfer = 1'b0;
    end
  endtask

  initial begin
    sreq_t r;
    rst = 1'b1;
    MEM_address = '0;
    MEM_write_data = '0;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    last_xfer = 1'b0;
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    @(negedge clk);
    chk("reset_re", 64'(SRAM_re_en), 64'd0);
    chk("reset_we", 64'(SRAM_we_en), 64'd0);
    chk("reset_addr", 64'(SRAM_address), 64'd0);
    chk("reset_wdata", 64'(SRAM_write_data), 64'd0);
    chk("reset_freeze", 64'(freeze), 64'd0);
    chk("reset_rdata", 64'(MEM_read_data), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    do_req(1'b0, 1'b1, 32'h400, 32'h0);
    do_req(1'b0, 1'b1, 32'h400, 32'h0);
    idle(1);
    do_req(1'b1, 1'b0, 32'h404, 32'h12345678);
    do_req(1'b0, 1'b1, 32'h404, 32'h0);
    idle(2);
    do_req(1'b0, 1'b1, 32'h400, 32'h0);
    do_req(1'b0, 1'b1, 32'h500, 32'h0);
    do_req(1'b0, 1'b1, 32'h400, 32'h0);
    idle(1);
    do_req(1'b0, 1'b1, 32'h408, 32'h0);
    do_req(1'b0, 1'b1, 32'h40C, 32'h0);
    idle(1);
    do_req(1'b1, 1'b1, 32'h410, 32'hCAFEF00D);
    do_req(1'b0, 1'b1, 32'h410, 32'h0);
    idle(1);

    // Reset in cycle 2 of a load miss: request is dropped, cache emptied.
    r = '{1'b0, 18'h100, 32'h0};
    exp_sram.push_back(r);
    MEM_address = 32'h600;
    MEM_R_EN = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_re", 64'(SRAM_re_en), 64'd0);
    chk("midrst_we", 64'(SRAM_we_en), 64'd0);
    chk("midrst_addr", 64'(SRAM_address), 64'd0);
    MEM_R_EN = 1'b0;
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_xfer = 1'b0;
    do_req(1'b0, 1'b1, 32'h600, 32'h0);

    for (int i = 0; i < 150; i++) begin
      int          op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      a  = 32'(BASE) + 32'(4 * $urandom_range(0, 3 * LINES - 1));
      if (op < 3)       do_req(1'b1, 1'b0, a, $urandom);
      else if (op == 3) do_req(1'b1, 1'b1, a, $urandom);
      else              do_req(1'b0, 1'b1, a, 32'h0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    idle(3);
    chk("load_left", 64'(exp_load.size()), 64'd0);
    chk("freeze_left", 64'(exp_freeze.size()), 64'd0);
    chk("sram_left", 64'(exp_sram.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
